// File: rtl/hazard_pkg.sv
// Shared constants, stall-cause encoding and helpers for the hazard controller.
package hazard_pkg;

    localparam int unsigned NREG_DEFAULT   = 32;
    localparam int unsigned LOAD_STALL_MIN = 1;
    localparam int unsigned LOAD_STALL_MAX = 3;
    // Wide enough to hold LOAD_STALL_MAX-1
    localparam int unsigned BUB_W          = 2;

    typedef enum logic [2:0] {
        CauseNone,
        CauseLoad,
        CauseRawMd,
        CauseStruct,
        CauseBranch
    } stall_cause_e;

    function automatic int unsigned reg_aw(input int unsigned nreg);
        return (nreg > 1) ? $clog2(nreg) : 1;
    endfunction

    function automatic int unsigned clamp_load_stall(input int unsigned n);
        if (n < LOAD_STALL_MIN) return LOAD_STALL_MIN;
        if (n > LOAD_STALL_MAX) return LOAD_STALL_MAX;
        return n;
    endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// Per-register pending-write scoreboard and busy flag for the multi-cycle unit.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int unsigned NREG   = NREG_DEFAULT,
    parameter int unsigned REG_AW = reg_aw(NREG)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              md_issue,
    input  logic [REG_AW-1:0] issue_rd,
    input  logic              wb_valid,
    input  logic [REG_AW-1:0] wb_rd,
    output logic [NREG-1:0]   sb_pending,
    output logic              md_busy
);

    logic [NREG-1:0] sb_q, sb_d;
    logic            busy_q, busy_d;

    always_comb begin
        sb_d = sb_q;
        if (wb_valid) begin
            sb_d[wb_rd] = 1'b0;
        end
        // Applied after the clear so a same-cycle issue to the same register wins
        if (md_issue && (issue_rd != '0)) begin
            sb_d[issue_rd] = 1'b1;
        end
        sb_d[0] = 1'b0;
    end

    always_comb begin
        busy_d = busy_q;
        if (md_issue) begin
            busy_d = 1'b1;
        end else if (wb_valid) begin
            busy_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sb_q   <= '0;
            busy_q <= 1'b0;
        end else begin
            sb_q   <= sb_d;
            busy_q <= busy_d;
        end
    end

    assign sb_pending = sb_q;
    assign md_busy    = busy_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles, RAW/structural stalls on the
// multi-cycle unit, branch flush priority and saturating performance counters.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned NREG       = NREG_DEFAULT,
    parameter int unsigned LOAD_STALL = 1,
    parameter int unsigned CNT_W      = 32,
    localparam int unsigned REG_AW    = reg_aw(NREG)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_rs1_used,
    input  logic              id_rs2_used,
    input  logic              id_is_md,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_mem_read,
    input  logic              ex_md_issue,
    input  logic              md_wb_valid,
    input  logic [REG_AW-1:0] md_wb_rd,
    input  logic              branch_taken,
    output logic              stall_if,
    output logic              stall_id,
    output logic              flush_if_id,
    output logic              flush_id_ex,
    output logic              md_busy,
    output logic [NREG-1:0]   sb_pending,
    output logic [CNT_W-1:0]  perf_stall_cycles,
    output logic [CNT_W-1:0]  perf_flush_events
);

    localparam logic [BUB_W-1:0] BUB_INIT = BUB_W'(clamp_load_stall(LOAD_STALL) - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    logic [BUB_W-1:0] bub_q, bub_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic             load_haz, raw_haz, struct_haz;
    stall_cause_e     cause;

    hazard_scoreboard #(
        .NREG   (NREG),
        .REG_AW (REG_AW)
    ) u_scoreboard (
        .clk        (clk),
        .rst_n      (rst_n),
        .md_issue   (ex_md_issue),
        .issue_rd   (ex_rd),
        .wb_valid   (md_wb_valid),
        .wb_rd      (md_wb_rd),
        .sb_pending (sb_pending),
        .md_busy    (md_busy)
    );

    assign load_haz = id_valid && ex_mem_read && (ex_rd != '0) &&
                      ((id_rs1_used && (ex_rd == id_rs1)) ||
                       (id_rs2_used && (ex_rd == id_rs2)));

    assign raw_haz = id_valid && ((id_rs1_used && sb_pending[id_rs1]) ||
                                  (id_rs2_used && sb_pending[id_rs2]));

    assign struct_haz = id_valid && id_is_md && md_busy;

    always_comb begin
        cause = CauseNone;
        if (branch_taken) begin
            cause = CauseBranch;
        end else if (load_haz || (bub_q != '0)) begin
            cause = CauseLoad;
        end else if (raw_haz) begin
            cause = CauseRawMd;
        end else if (struct_haz) begin
            cause = CauseStruct;
        end
    end

    always_comb begin
        stall_if    = 1'b0;
        stall_id    = 1'b0;
        flush_if_id = 1'b0;
        flush_id_ex = 1'b0;
        unique case (cause)
            CauseBranch: begin
                flush_if_id = 1'b1;
                flush_id_ex = 1'b1;
            end
            CauseLoad, CauseRawMd, CauseStruct: begin
                stall_if    = 1'b1;
                stall_id    = 1'b1;
                flush_id_ex = 1'b1;
            end
            default: ;
        endcase
        // Outputs are forced quiet for the whole reset window
        if (!rst_n) begin
            stall_if    = 1'b0;
            stall_id    = 1'b0;
            flush_if_id = 1'b0;
            flush_id_ex = 1'b0;
        end
    end

    always_comb begin
        bub_d = bub_q;
        if (branch_taken) begin
            bub_d = '0;
        end else if (load_haz) begin
            bub_d = BUB_INIT;
        end else if (bub_q != '0) begin
            bub_d = bub_q - BUB_W'(1);
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_id && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (flush_if_id && (flush_cnt_q != CNT_MAX)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bub_q       <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            bub_q       <= bub_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign perf_stall_cycles = stall_cnt_q;
    assign perf_flush_events = flush_cnt_q;

endmodule
